// File: rtl/grey_counter_pkg.sv
// Shared definitions for the Grey-code source counter.
package grey_counter_pkg;

    // Default counter width when the parent does not override it.
    localparam int unsigned GC_DEFAULT_WIDTH = 8;

    // The action chosen for the next edge, after priority resolution.
    typedef enum logic [1:0] {
        STEP_HOLD  = 2'd0,
        STEP_UP    = 2'd1,
        STEP_DOWN  = 2'd2,
        STEP_CLEAR = 2'd3
    } step_e;

endpackage

// File: rtl/grey_counter_binary_to_grey.sv
// Combinational binary-to-Grey encoder: adjacent binary values differ in one Grey bit.
module binary_to_grey #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] binary_i,
    output logic [WIDTH-1:0] grey_o
);

    // Each Grey bit is the XOR of a binary bit with the next more significant one.
    always_comb begin
        grey_o = binary_i ^ (binary_i >> 1);
    end

endmodule

// File: rtl/grey_counter.sv
// Up/down counter with a flop-driven Grey image, used as the source of Grey-coded
// pointers crossing into another clock domain.
module grey_counter
    import grey_counter_pkg::*;
#(
    parameter int WIDTH = GC_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             increment,
    input  logic             decrement,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] grey,
    output logic [WIDTH-1:0] binary_next,
    output logic [WIDTH-1:0] grey_next,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    step_e            step;
    logic [WIDTH-1:0] binary_q;
    logic [WIDTH-1:0] binary_d;
    logic [WIDTH-1:0] grey_q;
    logic [WIDTH-1:0] grey_d;
    logic             wrapped_q;
    logic             wrapped_d;

    // Resolve the inputs into one action: clear beats a single-sided step; both or neither holds.
    always_comb begin
        step = STEP_HOLD;
        if (clear) begin
            step = STEP_CLEAR;
        end else if (increment ^ decrement) begin
            step = increment ? STEP_UP : STEP_DOWN;
        end
    end

    // Next binary value and wrap flag for the chosen action.
    always_comb begin
        binary_d  = binary_q;
        wrapped_d = 1'b0;
        case (step)
            STEP_CLEAR: begin
                binary_d = ALL_ZERO;
            end
            STEP_UP: begin
                binary_d  = binary_q + WIDTH'(1);
                wrapped_d = (binary_q == ALL_ONES);
            end
            STEP_DOWN: begin
                binary_d  = binary_q - WIDTH'(1);
                wrapped_d = (binary_q == ALL_ZERO);
            end
            default: begin
                binary_d = binary_q;
            end
        endcase
    end

    // Grey image is encoded from the next binary value so the grey flops load it directly.
    binary_to_grey #(
        .WIDTH(WIDTH)
    ) u_binary_to_grey (
        .binary_i(binary_d),
        .grey_o  (grey_d)
    );

    // Binary, Grey and wrap registers; reset drops all of them to zero immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            binary_q  <= ALL_ZERO;
            grey_q    <= ALL_ZERO;
            wrapped_q <= 1'b0;
        end else begin
            binary_q  <= binary_d;
            grey_q    <= grey_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign binary      = binary_q;
    assign grey        = grey_q;
    assign binary_next = binary_d;
    assign grey_next   = grey_d;
    assign wrapped     = wrapped_q;

endmodule
